// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller.
// Sequences an external tag/valid/dirty + 128-bit data block store and a next-level memory port.
module cache_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 10,
  parameter int OFFSET_WIDTH = 4,
  parameter int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_WIDTH-1:0]  cpu_addr,
  input  logic [3:0]             cpu_be,
  input  logic [31:0]            cpu_wdata,
  output logic [31:0]            cpu_rdata,
  output logic                   cpu_ready,
  output logic                   init_done,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [127:0]           mem_wdata,
  input  logic [127:0]           mem_rdata,
  input  logic                   mem_ack,
  output logic                   blk_en,
  output logic                   blk_we,
  output logic [INDEX_WIDTH-1:0] blk_index,
  output logic [3:0]             blk_en_word,
  output logic [3:0]             blk_en_byte,
  output logic                   blk_valid_new,
  output logic                   blk_dirty_new,
  output logic [TAG_WIDTH-1:0]   blk_tag_in,
  output logic [127:0]           blk_data_in,
  input  logic                   blk_valid,
  input  logic                   blk_dirty,
  input  logic [TAG_WIDTH-1:0]   blk_tag,
  input  logic [127:0]           blk_data,
  output logic [CNT_WIDTH-1:0]   hit_cnt,
  output logic [CNT_WIDTH-1:0]   miss_cnt
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LOOKUP, S_WB, S_FETCH, S_FILL
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = '1;
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX    = '1;

  state_t state, state_next;

  logic                   started;
  logic                   nop_ack;
  logic [INDEX_WIDTH-1:0] init_idx;

  logic [TAG_WIDTH-1:0]   req_tag;
  logic [INDEX_WIDTH-1:0] req_index;
  logic [1:0]             req_word;
  logic                   req_we;
  logic [3:0]             req_be;
  logic [31:0]            req_wdata;

  logic [TAG_WIDTH-1:0]   victim_tag;
  logic [127:0]           victim_data;
  logic [127:0]           fill_line;

  logic is_nop, accept, hit, dirty_miss;
  logic unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];

  // While a be=0 completion pulse is out, only another be=0 store may be taken,
  // so cpu_ready is never high on two consecutive cycles for any other pairing.
  assign is_nop     = cpu_we && (cpu_be == 4'b0000);
  assign accept     = (state == S_IDLE) && cpu_req && (is_nop || !nop_ack);
  assign hit        = blk_valid && (blk_tag == req_tag);
  assign dirty_miss = !hit && blk_valid && blk_dirty;

  function automatic logic [127:0] merge_word(input logic [127:0] line,
                                              input logic [1:0]   word,
                                              input logic [3:0]   be,
                                              input logic [31:0]  data);
    logic [127:0] res;
    res = line;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[int'(word)*32 + b*8 +: 8] = data[b*8 +: 8];
    end
    return res;
  endfunction

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_next    = state;
    cpu_ready     = nop_ack;
    cpu_rdata     = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    blk_en        = 1'b0;
    blk_we        = 1'b0;
    blk_index     = req_index;
    blk_en_word   = 4'b0000;
    blk_en_byte   = 4'b0000;
    blk_valid_new = 1'b0;
    blk_dirty_new = 1'b0;
    blk_tag_in    = '0;
    blk_data_in   = '0;

    unique case (state)
      S_INIT: begin
        if (started) begin
          blk_en      = 1'b1;
          blk_we      = 1'b1;
          blk_index   = init_idx;
          blk_en_word = 4'b1111;
          blk_en_byte = 4'b1111;
          if (init_idx == LAST_INDEX) state_next = S_IDLE;
        end
      end

      S_IDLE: begin
        blk_index = cpu_addr[OFFSET_WIDTH +: INDEX_WIDTH];
        if (accept && !is_nop) begin
          blk_en     = 1'b1;
          state_next = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (hit) begin
          cpu_ready  = 1'b1;
          state_next = S_IDLE;
          if (req_we) begin
            blk_en        = 1'b1;
            blk_we        = 1'b1;
            blk_en_word   = 4'b0001 << req_word;
            blk_en_byte   = req_be;
            blk_valid_new = 1'b1;
            blk_dirty_new = 1'b1;
            blk_tag_in    = req_tag;
            blk_data_in   = {4{req_wdata}};
          end else begin
            cpu_rdata = blk_data[{req_word, 5'd0} +: 32];
          end
        end else if (dirty_miss) begin
          state_next = S_WB;
        end else begin
          state_next = S_FETCH;
        end
      end

      S_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {victim_tag, req_index, {OFFSET_WIDTH{1'b0}}};
        mem_wdata = victim_data;
        if (mem_ack) state_next = S_FETCH;
      end

      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_index, {OFFSET_WIDTH{1'b0}}};
        if (mem_ack) state_next = S_FILL;
      end

      S_FILL: begin
        blk_en        = 1'b1;
        blk_we        = 1'b1;
        blk_en_word   = 4'b1111;
        blk_en_byte   = 4'b1111;
        blk_valid_new = 1'b1;
        blk_tag_in    = req_tag;
        cpu_ready     = 1'b1;
        state_next    = S_IDLE;
        if (req_we) begin
          blk_data_in   = merge_word(fill_line, req_word, req_be, req_wdata);
          blk_dirty_new = 1'b1;
        end else begin
          blk_data_in = fill_line;
          cpu_rdata   = fill_line[{req_word, 5'd0} +: 32];
        end
      end

      default: state_next = S_INIT;
    endcase
  end

  // NOTE: the block store has no reset of its own; its valid bits are cleared by the
  // INIT sweep, and only the registers in this controller are reset by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_INIT;
      started     <= 1'b0;
      nop_ack     <= 1'b0;
      init_idx    <= '0;
      init_done   <= 1'b0;
      req_tag     <= '0;
      req_index   <= '0;
      req_word    <= '0;
      req_we      <= 1'b0;
      req_be      <= '0;
      req_wdata   <= '0;
      victim_tag  <= '0;
      victim_data <= '0;
      fill_line   <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state   <= state_next;
      started <= 1'b1;
      nop_ack <= accept && is_nop;

      if (state == S_INIT && started) begin
        init_idx <= init_idx + 1'b1;
        if (init_idx == LAST_INDEX) init_done <= 1'b1;
      end

      if (accept) begin
        req_tag   <= cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
        req_index <= cpu_addr[OFFSET_WIDTH +: INDEX_WIDTH];
        req_word  <= cpu_addr[3:2];
        req_we    <= cpu_we;
        req_be    <= cpu_be;
        req_wdata <= cpu_wdata;
      end

      // Stored line is only presented during LOOKUP, so the victim is captured there.
      if (state == S_LOOKUP && dirty_miss) begin
        victim_tag  <= blk_tag;
        victim_data <= blk_data;
      end

      if (state == S_FETCH && mem_ack) fill_line <= mem_rdata;

      if (state == S_LOOKUP && hit && hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + 1'b1;
      if (state == S_FILL && miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: behavioural block store and next-level memory around the DUT,
// hand-computed expected values for the init sweep, hits, misses, writeback and mid-WB reset.
module tb_cache_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [3:0]   cpu_be = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [31:0]  cpu_rdata;
  logic         cpu_ready;
  logic         init_done;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;
  logic         blk_en;
  logic         blk_we;
  logic [9:0]   blk_index;
  logic [3:0]   blk_en_word;
  logic [3:0]   blk_en_byte;
  logic         blk_valid_new;
  logic         blk_dirty_new;
  logic [17:0]  blk_tag_in;
  logic [127:0] blk_data_in;
  logic         blk_valid = 1'b0;
  logic         blk_dirty = 1'b0;
  logic [17:0]  blk_tag = '0;
  logic [127:0] blk_data = '0;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .init_done(init_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .blk_en(blk_en), .blk_we(blk_we), .blk_index(blk_index), .blk_en_word(blk_en_word),
    .blk_en_byte(blk_en_byte), .blk_valid_new(blk_valid_new), .blk_dirty_new(blk_dirty_new),
    .blk_tag_in(blk_tag_in), .blk_data_in(blk_data_in),
    .blk_valid(blk_valid), .blk_dirty(blk_dirty), .blk_tag(blk_tag), .blk_data(blk_data),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Block store: one-cycle synchronous read, byte/word masked write.
  logic         m_valid [1024];
  logic         m_dirty [1024];
  logic [17:0]  m_tag   [1024];
  logic [127:0] m_data  [1024];
  int           n_reads = 0;
  int           n_writes = 0;
  int           init_wr_cnt = 0;
  logic         init_order_err = 1'b0;
  logic [9:0]   last_rd_idx = '0;
  logic [3:0]   last_wr_word = '0;
  logic [3:0]   last_wr_byte = '0;
  logic         last_wr_dirty = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      init_wr_cnt    <= 0;
      init_order_err <= 1'b0;
      for (int i = 0; i < 1024; i++) begin
        m_valid[i] <= 1'b1;
        m_dirty[i] <= 1'b1;
        m_tag[i]   <= 18'h3ffff;
      end
    end else begin
      if (blk_en && !blk_we) begin
        blk_valid   <= m_valid[blk_index];
        blk_dirty   <= m_dirty[blk_index];
        blk_tag     <= m_tag[blk_index];
        blk_data    <= m_data[blk_index];
        n_reads     <= n_reads + 1;
        last_rd_idx <= blk_index;
      end
      if (blk_en && blk_we) begin
        for (int w = 0; w < 4; w++)
          for (int b = 0; b < 4; b++)
            if (blk_en_word[w] && blk_en_byte[b])
              m_data[blk_index][w*32 + b*8 +: 8] <= blk_data_in[w*32 + b*8 +: 8];
        m_valid[blk_index] <= blk_valid_new;
        m_dirty[blk_index] <= blk_dirty_new;
        m_tag[blk_index]   <= blk_tag_in;
        n_writes      <= n_writes + 1;
        last_wr_word  <= blk_en_word;
        last_wr_byte  <= blk_en_byte;
        last_wr_dirty <= blk_dirty_new;
        if (!blk_valid_new) begin
          if (blk_index != 10'(init_wr_cnt) || blk_dirty_new || blk_tag_in != '0 ||
              blk_data_in != '0 || blk_en_word != 4'hf || blk_en_byte != 4'hf)
            init_order_err <= 1'b1;
          init_wr_cnt <= init_wr_cnt + 1;
        end
      end
    end
  end

  // Next-level memory: acks three cycles into a request unless stalled.
  logic [127:0] mem_store [logic [31:0]];
  logic         mem_stall = 1'b0;
  int           mem_wait = 0;
  int           n_wb = 0;
  int           n_fetch = 0;
  logic [31:0]  last_wb_addr = '0;
  logic [31:0]  last_fetch_addr = '0;
  logic [127:0] last_wb_data = '0;

  function automatic logic [127:0] mem_init(input logic [31:0] a);
    if (a == 32'h0000_1230) return {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
    return {a ^ 32'hA5A5_0003, a ^ 32'hA5A5_0002, a ^ 32'hA5A5_0001, a ^ 32'hA5A5_0000};
  endfunction

  always @(negedge clk) begin
    if (!rst_n || mem_ack) begin
      mem_ack  = 1'b0;
      mem_wait = 0;
    end else if (mem_req && !mem_stall) begin
      if (mem_wait == 2) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          mem_store[mem_addr] = mem_wdata;
          n_wb++;
          last_wb_addr = mem_addr;
          last_wb_data = mem_wdata;
        end else begin
          mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : mem_init(mem_addr);
          n_fetch++;
          last_fetch_addr = mem_addr;
        end
      end else begin
        mem_wait++;
      end
    end
  end

  task automatic wait_ready(input string tag, output logic [31:0] rdata, output int cycles);
    cycles = 1;
    while (!cpu_ready && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_ready"}, cpu_ready, 1'b1);
    rdata = cpu_rdata;
    @(negedge clk);
  endtask

  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int cycles);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = wdata;
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
    wait_ready(tag, rdata, cycles);
  endtask

  task automatic wait_init(output int cycles);
    cycles = 0;
    while (!init_done && cycles < 1200) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int cyc, reads0, writes0;

    // Reset with a load already requested; it must wait out the sweep.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1234;
    repeat (3) @(negedge clk);
    check("rst_init_done", init_done, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_cpu_ready", cpu_ready, 1'b0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    check("rst_blk_en", blk_en, 1'b0);
    rst_n = 1'b1;

    wait_init(cyc);
    check("init_done", init_done, 1'b1);
    check("init_writes", init_wr_cnt, 1024);
    check("init_order", init_order_err, 1'b0);
    check("init_no_reads", n_reads, 0);
    @(negedge clk);
    check("first_accept", n_reads, 1);
    check("first_index", last_rd_idx, 10'h123);
    cpu_req = 1'b0; cpu_addr = '0;
    wait_ready("miss1", rd, cyc);
    check("miss1_rdata", rd, 32'hDEAD_BEEF);
    check("miss1_fetch_addr", last_fetch_addr, 32'h0000_1230);
    check("miss1_fetches", n_fetch, 1);
    check("miss1_miss_cnt", miss_cnt, 1);
    check("miss1_valid", m_valid[10'h123], 1'b1);
    check("miss1_clean", m_dirty[10'h123], 1'b0);
    check("miss1_tag", m_tag[10'h123], 18'h0);

    // Repeat load: hit, no memory traffic.
    do_req("hit1", 1'b0, 32'h0000_1234, 4'b0000, '0, rd, cyc);
    check("hit1_latency", cyc, 1);
    check("hit1_rdata", rd, 32'hDEAD_BEEF);
    check("hit1_hit_cnt", hit_cnt, 1);
    check("hit1_fetches", n_fetch, 1);

    // Store hit on the low half of word 1.
    do_req("st_hit", 1'b1, 32'h0000_1234, 4'b0011, 32'h0000_5678, rd, cyc);
    check("st_hit_latency", cyc, 1);
    check("st_hit_en_word", last_wr_word, 4'b0010);
    check("st_hit_en_byte", last_wr_byte, 4'b0011);
    check("st_hit_dirty_new", last_wr_dirty, 1'b1);
    check("st_hit_dirty", m_dirty[10'h123], 1'b1);
    check("st_hit_hit_cnt", hit_cnt, 2);
    do_req("ld_merged", 1'b0, 32'h0000_1234, 4'b0000, '0, rd, cyc);
    check("ld_merged_rdata", rd, 32'hDEAD_5678);
    check("ld_merged_hit_cnt", hit_cnt, 3);

    // Store with no byte enables: completes without touching anything.
    reads0 = n_reads; writes0 = n_writes;
    do_req("nop_st", 1'b1, 32'h0000_1234, 4'b0000, 32'hFFFF_FFFF, rd, cyc);
    check("nop_st_latency", cyc, 1);
    check("nop_st_reads", n_reads, reads0);
    check("nop_st_writes", n_writes, writes0);
    check("nop_st_hit_cnt", hit_cnt, 3);
    check("nop_st_miss_cnt", miss_cnt, 1);

    // Conflict miss on a dirty line: writeback then refill.
    do_req("conflict", 1'b0, 32'h0004_1234, 4'b0000, '0, rd, cyc);
    check("conflict_rdata", rd, 32'hA5A1_1231);
    check("conflict_wbs", n_wb, 1);
    check("conflict_wb_addr", last_wb_addr, 32'h0000_1230);
    check("conflict_wb_data", last_wb_data,
          {32'h3333_3333, 32'h2222_2222, 32'hDEAD_5678, 32'h1111_1111});
    check("conflict_fetch_addr", last_fetch_addr, 32'h0004_1230);
    check("conflict_tag", m_tag[10'h123], 18'h10);
    check("conflict_clean", m_dirty[10'h123], 1'b0);
    check("conflict_miss_cnt", miss_cnt, 2);

    // Store miss on an invalid line: refill merged with store bytes, no writeback.
    do_req("st_miss", 1'b1, 32'h0000_2008, 4'b1100, 32'hAABB_CCDD, rd, cyc);
    check("st_miss_wbs", n_wb, 1);
    check("st_miss_line", m_data[10'h200],
          {32'hA5A5_2003, 32'hAABB_2002, 32'hA5A5_2001, 32'hA5A5_2000});
    check("st_miss_dirty", m_dirty[10'h200], 1'b1);
    check("st_miss_miss_cnt", miss_cnt, 3);
    do_req("st_miss_ld", 1'b0, 32'h0000_2008, 4'b0000, '0, rd, cyc);
    check("st_miss_ld_rdata", rd, 32'hAABB_2002);
    check("st_miss_ld_hit_cnt", hit_cnt, 4);

    // Reset while a writeback is outstanding.
    mem_stall = 1'b1;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0008_2000; cpu_be = '0;
    @(negedge clk);
    cpu_req = 1'b0; cpu_addr = '0;
    cyc = 0;
    while (!(mem_req && mem_we) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("wb_pending", mem_req && mem_we, 1'b1);
    check("wb_pending_addr", mem_addr, 32'h0000_2000);
    rst_n = 1'b0;
    #1;
    check("mid_rst_mem_req", mem_req, 1'b0);
    check("mid_rst_cpu_ready", cpu_ready, 1'b0);
    check("mid_rst_hit_cnt", hit_cnt, 0);
    check("mid_rst_miss_cnt", miss_cnt, 0);
    check("mid_rst_init_done", init_done, 1'b0);
    repeat (3) @(negedge clk);
    mem_stall = 1'b0;
    rst_n = 1'b1;
    wait_init(cyc);
    check("reinit_done", init_done, 1'b1);
    check("reinit_writes", init_wr_cnt, 1024);
    check("reinit_order", init_order_err, 1'b0);

    // Cache is empty again; the earlier writeback holds the modified line.
    do_req("post_rst", 1'b0, 32'h0000_1234, 4'b0000, '0, rd, cyc);
    check("post_rst_rdata", rd, 32'hDEAD_5678);
    check("post_rst_miss_cnt", miss_cnt, 1);
    check("post_rst_hit_cnt", hit_cnt, 0);
    check("post_rst_wbs", n_wb, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
